// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : fills instruction memory from a byte stream, holding the core
//               in reset until the load completes.  Revision: 1.0
// ============================================================================
module imem_loader #(
   parameter int unsigned            addBusWidth  = 20,
   parameter int unsigned            width        = 16,
   parameter logic [addBusWidth-1:0] startAddress = 'h20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   memWR,
   output logic [addBusWidth-1:0] addWR,
   output logic [width-1:0]       dataWR,
   output logic                   cpu_hold,
   output logic                   done,
   output logic [15:0]            words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CNT_LO = 3'd1,
      S_CNT_HI = 3'd2,
      S_DAT_LO = 3'd3,
      S_DAT_HI = 3'd4,
      S_WRITE  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t                 r_state;
   logic [15:0]            r_count;
   logic [7:0]             r_word_lo;
   logic [addBusWidth-1:0] r_addr;
   logic                   w_xfer;

   assign w_xfer = in_valid && in_ready;

   // in_ready is registered, so it is set on the edge that enters a receive state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_count      <= 16'd0;
         r_word_lo    <= 8'd0;
         r_addr       <= '0;
         in_ready     <= 1'b0;
         memWR        <= 1'b0;
         addWR        <= '0;
         dataWR       <= '0;
         cpu_hold     <= 1'b0;
         done         <= 1'b0;
         words_loaded <= 16'd0;
      end else begin
         memWR <= 1'b0;
         done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state      <= S_CNT_LO;
                  in_ready     <= 1'b1;
                  cpu_hold     <= 1'b1;
                  words_loaded <= 16'd0;
                  r_addr       <= startAddress;
               end
            end
            S_CNT_LO: begin
               if (w_xfer) begin
                  r_count[7:0] <= in_data;
                  r_state      <= S_CNT_HI;
               end
            end
            S_CNT_HI: begin
               if (w_xfer) begin
                  r_count[15:8] <= in_data;
                  if ({in_data, r_count[7:0]} == 16'd0) begin
                     r_state  <= S_DONE;
                     in_ready <= 1'b0;
                  end else begin
                     r_state <= S_DAT_LO;
                  end
               end
            end
            S_DAT_LO: begin
               if (w_xfer) begin
                  r_word_lo <= in_data;
                  r_state   <= S_DAT_HI;
               end
            end
            S_DAT_HI: begin
               if (w_xfer) begin
                  memWR    <= 1'b1;
                  addWR    <= r_addr;
                  dataWR   <= {in_data, r_word_lo};
                  in_ready <= 1'b0;
                  r_state  <= S_WRITE;
               end
            end
            S_WRITE: begin
               r_addr       <= r_addr + 1'b1;
               words_loaded <= words_loaded + 16'd1;
               if ((words_loaded + 16'd1) == r_count) begin
                  r_state <= S_DONE;
               end else begin
                  r_state  <= S_DAT_LO;
                  in_ready <= 1'b1;
               end
            end
            S_DONE: begin
               done     <= 1'b1;
               cpu_hold <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state  <= S_IDLE;
               in_ready <= 1'b0;
               cpu_hold <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader : randomized byte-stream loads checked against a write-list
//                  model; a second instance sits at the top of the address map.
// ============================================================================
module tb_imem_loader;

   localparam int AW = 20;

   logic clk = 1'b0;
   logic rst, start, in_valid;
   logic [7:0] in_data;

   logic          in_ready0, memWR0, cpu_hold0, done0;
   logic [AW-1:0] addWR0;
   logic [15:0]   dataWR0, words0;
   logic          in_ready1, memWR1, cpu_hold1, done1;
   logic [AW-1:0] addWR1;
   logic [15:0]   dataWR1, words1;

   always #5 clk = ~clk;

   imem_loader #(.addBusWidth(AW), .width(16), .startAddress(20'h00020)) dut0 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready0), .memWR(memWR0), .addWR(addWR0), .dataWR(dataWR0),
      .cpu_hold(cpu_hold0), .done(done0), .words_loaded(words0));

   imem_loader #(.addBusWidth(AW), .width(16), .startAddress(20'hFFFFF)) dut1 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready1), .memWR(memWR1), .addWR(addWR1), .dataWR(dataWR1),
      .cpu_hold(cpu_hold1), .done(done1), .words_loaded(words1));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Model: the list of (address, data) writes each instance must still make.
   logic [AW-1:0] q_addr0[$], q_addr1[$];
   logic [15:0]   q_data0[$], q_data1[$];
   logic [15:0]   fixed_words[$];
   logic [15:0]   exp_words = 16'd0;
   int            done_seen = 0;

   always @(negedge clk) begin
      if (memWR0) begin
         check("ready_low_during_write0", 32'(in_ready0), 32'd0);
         if (q_addr0.size() == 0) check("spurious_write0", 32'(memWR0), 32'd0);
         else begin
            check("addWR0", 32'(addWR0), 32'(q_addr0.pop_front()));
            check("dataWR0", 32'(dataWR0), 32'(q_data0.pop_front()));
         end
      end
      if (memWR1) begin
         check("ready_low_during_write1", 32'(in_ready1), 32'd0);
         if (q_addr1.size() == 0) check("spurious_write1", 32'(memWR1), 32'd0);
         else begin
            check("addWR_wrap", 32'(addWR1), 32'(q_addr1.pop_front()));
            check("dataWR_wrap", 32'(dataWR1), 32'(q_data1.pop_front()));
         end
      end
      if (done0) begin
         done_seen++;
         check("words_at_done", 32'(words0), 32'(exp_words));
         check("hold_low_at_done", 32'(cpu_hold0), 32'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_model();
      q_addr0.delete(); q_data0.delete();
      q_addr1.delete(); q_data1.delete();
   endtask

   // start_pulse_idx: byte index at which start is re-pulsed (-1: never).
   // abort_after: reset right after this many words are written (0: never).
   task automatic run_load(input int n, input int stall_pct, input int start_pulse_idx,
                           input int abort_after);
      logic [7:0]  bytes[$];
      logic [15:0] w;
      logic [15:0] n16;
      int          idx, guard, done_before, r;
      bit          xfer, pulsed;
      n16 = 16'(n);
      bytes.push_back(n16[7:0]);
      bytes.push_back(n16[15:8]);
      for (int i = 0; i < n; i++) begin
         if (fixed_words.size() != 0) w = fixed_words.pop_front();
         else w = 16'($urandom);
         bytes.push_back(w[7:0]);
         bytes.push_back(w[15:8]);
         q_addr0.push_back(AW'(32'h00020 + i));
         q_addr1.push_back(AW'(32'hFFFFF + i));
         q_data0.push_back(w);
         q_data1.push_back(w);
      end
      exp_words   = n16;
      done_before = done_seen;

      start = 1'b1;
      step();
      start = 1'b0;
      check("hold_on_start", 32'(cpu_hold0), 32'd1);
      check("ready_on_start", 32'(in_ready0), 32'd1);

      idx = 0; guard = 0; pulsed = 1'b0;
      while (idx < bytes.size()) begin
         r        = int'($urandom_range(99));
         in_valid = (r >= stall_pct);
         in_data  = in_valid ? bytes[idx] : 8'($urandom);
         if (idx == start_pulse_idx && !pulsed) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
         xfer = in_valid && in_ready0;
         step();
         start    = 1'b0;
         in_valid = 1'b0;
         if (xfer) begin
            idx++;
            if (idx >= 4 && (idx % 2) == 0) begin
               check("write_latency", 32'(memWR0), 32'd1);
               check("ready_low_in_write", 32'(in_ready0), 32'd0);
               if (abort_after > 0 && idx == 2 + 2 * abort_after) begin
                  rst = 1'b1;
                  step();
                  rst = 1'b0;
                  flush_model();
                  check("abort_ready", 32'(in_ready0), 32'd0);
                  check("abort_hold", 32'(cpu_hold0), 32'd0);
                  check("abort_memwr", 32'(memWR0), 32'd0);
                  check("abort_words", 32'(words0), 32'd0);
                  return;
               end
            end
         end
         guard++;
         if (guard > 4000) begin
            check("byte_stream_timeout", 32'(idx), 32'(bytes.size()));
            return;
         end
      end

      if (n == 0) begin
         check("done_early", 32'(done0), 32'd0);
         step();
         check("done_zero_count", 32'(done0), 32'd1);
      end else begin
         step();
         check("done_early", 32'(done0), 32'd0);
         check("hold_in_done_state", 32'(cpu_hold0), 32'd1);
         step();
         check("done_pulse", 32'(done0), 32'd1);
      end
      check("hold_falls_with_done", 32'(cpu_hold0), 32'd0);
      check("words_loaded", 32'(words0), 32'(n16));
      check("words_loaded_wrap", 32'(words1), 32'(n16));
      step();
      check("done_single_cycle", 32'(done0), 32'd0);
      check("done_count", 32'(done_seen - done_before), 32'd1);
      check("writes_missing0", 32'(q_addr0.size()), 32'd0);
      check("writes_missing1", 32'(q_addr1.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      step();
      step();
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready0), 32'd0);
      check("rst_memWR", 32'(memWR0), 32'd0);
      check("rst_addWR", 32'(addWR0), 32'd0);
      check("rst_dataWR", 32'(dataWR0), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold0), 32'd0);
      check("rst_done", 32'(done0), 32'd0);
      check("rst_words", 32'(words0), 32'd0);
      step();

      // Basic two-word load (also the wrap case on the second instance)
      fixed_words.push_back(16'h1234);
      fixed_words.push_back(16'h5678);
      run_load(2, 0, -1, 0);

      // Zero count
      run_load(0, 0, -1, 0);

      // Four words under random backpressure
      run_load(4, 50, -1, 0);

      // Reset after the first of three words, then a clean one-word load
      run_load(3, 20, -1, 1);
      step();
      fixed_words.push_back(16'hABCD);
      run_load(1, 0, -1, 0);

      // start re-pulsed while waiting for the first data byte
      run_load(3, 30, 2, 0);

      for (int t = 0; t < 4; t++) begin
         run_load(int'($urandom_range(6, 1)), int'($urandom_range(60)), -1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks", n_pass, n_checks);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the instruction fetch path: fills instruction memory before the core starts fetching.
- Accepts a byte stream over a valid/ready handshake. The first two bytes are a 16-bit word count; the remaining bytes pair into 16-bit instructions.
- Each instruction is written to the instruction memory write port at consecutive addresses starting at the reset PC value (0x20).
- Holds the core in reset (cpu_hold) while loading and releases it when done.

Parameters:
- addBusWidth, 20, instruction memory address width.
- width, 16, instruction word width; fixed at 16 (two bytes per word).
- startAddress, 'h20, address of the first loaded word; equals the PC reset value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; begins a load when idle.
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte stream data.
- in_ready  out  1  loader can accept a byte this cycle.
- memWR  out  1  instruction memory write enable, one-cycle pulse per word.
- addWR  out  addBusWidth  write address.
- dataWR  out  width  write data.
- cpu_hold  out  1  high from start until done; drives core reset.
- done  out  1  one-cycle pulse when the load completes.
- words_loaded  out  16  count of words written in the current or last load.

Behaviour:
- Reset (rst high at posedge): state=IDLE; in_ready=0, memWR=0, addWR=0, dataWR=0, cpu_hold=0, done=0, words_loaded=0. Reset mid-load aborts immediately; words already written stay in memory.
- A byte transfers on a posedge where in_valid && in_ready. in_data is ignored otherwise.
- States and transitions:
  - IDLE: in_ready=0. On start, go to CNT_LO, set cpu_hold=1, words_loaded=0, address register=startAddress.
  - CNT_LO: in_ready=1. Byte transfer latches count[7:0]; go to CNT_HI.
  - CNT_HI: in_ready=1. Byte transfer latches count[15:8]. Go to DONE if the full count is 0, else to DAT_LO.
  - DAT_LO: in_ready=1. Byte transfer latches word[7:0]; go to DAT_HI.
  - DAT_HI: in_ready=1. Byte transfer latches word[15:8]; go to WRITE.
  - WRITE: in_ready=0. Drive memWR=1, addWR=address register, dataWR=word for exactly one cycle. Then increment the address register and words_loaded. Go to DONE if words_loaded+1==count, else to DAT_LO.
  - DONE: done=1 for one cycle; cpu_hold drops the same cycle. Go to IDLE.
- Latency: the memWR pulse comes 1 cycle after the high byte is accepted. Minimum throughput is 3 cycles per word.
- memWR is registered. addWR and dataWR hold their last values when memWR=0.
- start outside IDLE is ignored. start is sampled only in IDLE.
- Address arithmetic is modulo 2^addBusWidth: a load that runs past the top address wraps to 0.
- A stall (in_valid low) in any receive state holds state, count and word unchanged, with no timeout.
- Count is the full 16 bits; maximum 65535 words.
- cpu_hold is high in every state except IDLE.

Test Plan:
- Basic load: start, then bytes 02 00 34 12 78 56 -> memWR pulses with (addWR=0x20, dataWR=0x1234) then (0x21, 0x5678); done pulses once; words_loaded=2; cpu_hold falls with done.
- Zero count: start, then bytes 00 00 -> no memWR; done 2 cycles after the second byte is accepted; words_loaded=0.
- Backpressure/stalls: in_valid toggled randomly over a 4-word load -> the written words and addresses 0x20..0x23 are exactly as sent; in_ready=0 during every WRITE cycle.
- Reset mid-load: rst asserted after the first word is written of a 3-word load -> next cycle in_ready=0, cpu_hold=0, memWR=0, state IDLE. A new start plus 01 00 CD AB then writes 0xABCD at 0x20.
- Ignored start: start pulsed during DAT_LO -> no effect on count, address or words_loaded; the load finishes normally.
- Wrap: startAddress overridden to 'hFFFFF, 2-word load -> writes land at 0xFFFFF then 0x00000.
